// File: rtl/frame_receiver_if.sv
// UART byte stream in, validated scoreboard frame out.
// FRAME_STATS_EN adds good_count/bad_count.
interface frame_receiver_if #(
   parameter int NUM_BYTES = 20
);
   logic [7:0]                 rx_byte;
   logic                       rx_valid;
   logic                       rx_err;
   logic [NUM_BYTES-1:0][7:0]  data_out;
   logic                       frame_strobe;
   logic                       frame_err_strobe;
   logic                       stale;
`ifdef FRAME_STATS_EN
   logic [15:0]                good_count;
   logic [15:0]                bad_count;

   modport master (
      output rx_byte, rx_valid, rx_err,
      input  data_out, frame_strobe, frame_err_strobe, stale,
      input  good_count, bad_count
   );
   modport slave (
      input  rx_byte, rx_valid, rx_err,
      output data_out, frame_strobe, frame_err_strobe, stale,
      output good_count, bad_count
   );
`else
   modport master (
      output rx_byte, rx_valid, rx_err,
      input  data_out, frame_strobe, frame_err_strobe, stale
   );
   modport slave (
      input  rx_byte, rx_valid, rx_err,
      output data_out, frame_strobe, frame_err_strobe, stale
   );
`endif
endinterface

// File: rtl/frame_receiver.sv
// Sync/payload/checksum frame assembler with gap abort and stale blanking.
// Optional macro FRAME_STATS_EN adds saturating good/bad frame counters.
module frame_receiver #(
   parameter int         NUM_BYTES    = 20,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         GAP_CYCLES   = 50000,
   parameter int         STALE_CYCLES = 50000000
) (
   input logic             clk,
   input logic             rst_n,
   frame_receiver_if.slave bus
);
   localparam int IW = $clog2(NUM_BYTES) + 1;
   localparam int GW = $clog2(GAP_CYCLES) + 1;
   localparam int SW = $clog2(STALE_CYCLES) + 1;

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_e;

   state_e                    state_q;
   logic [IW-1:0]             idx_q;
   logic [7:0]                sum_q;
   logic [GW-1:0]             gap_q, gap_d;
   logic [SW-1:0]             stale_cnt_q, stale_cnt_d;
   logic [NUM_BYTES-1:0][7:0] shadow_q;
   logic [NUM_BYTES-1:0][7:0] data_q;
   logic                      strobe_q, err_q, stale_q;

   logic       byte_ok, in_frame, gap_hit;
   logic       commit, reject, stale_hit;
   logic [7:0] cks_sum;

   always_comb begin
      byte_ok  = bus.rx_valid & ~bus.rx_err;
      in_frame = (state_q != HUNT);
      cks_sum  = sum_q + bus.rx_byte;
      gap_hit  = in_frame & ~bus.rx_valid & ~bus.rx_err
               & (gap_q == GW'(GAP_CYCLES - 1));
      commit   = (state_q == CHECK) & byte_ok & (cks_sum == 8'd0);
      reject   = in_frame & (bus.rx_err | gap_hit
               | ((state_q == CHECK) & byte_ok & (cks_sum != 8'd0)));
      // gap timer restarts on every accepted byte and idles outside a frame
      gap_d = '0;
      if (in_frame && !byte_ok && !gap_hit && !bus.rx_err)
         gap_d = gap_q + GW'(1);
      stale_cnt_d = stale_cnt_q;
      if (commit)
         stale_cnt_d = '0;
      else if (stale_cnt_q != SW'(STALE_CYCLES))
         stale_cnt_d = stale_cnt_q + SW'(1);
      stale_hit = (stale_cnt_d == SW'(STALE_CYCLES));
   end

`ifdef FRAME_STATS_EN
   logic [15:0] good_q, bad_q;
   assign bus.good_count = good_q;
   assign bus.bad_count  = bad_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         idx_q       <= '0;
         sum_q       <= '0;
         gap_q       <= '0;
         stale_cnt_q <= '0;
         shadow_q    <= '0;
         data_q      <= '0;
         strobe_q    <= 1'b0;
         err_q       <= 1'b0;
         stale_q     <= 1'b1;
`ifdef FRAME_STATS_EN
         good_q      <= '0;
         bad_q       <= '0;
`endif
      end else begin
         strobe_q    <= commit;
         err_q       <= reject;
         gap_q       <= gap_d;
         stale_cnt_q <= stale_cnt_d;
         if (commit) begin
            data_q  <= shadow_q;
            stale_q <= 1'b0;
         end else if (stale_hit) begin
            data_q  <= '0;
            stale_q <= 1'b1;
         end
`ifdef FRAME_STATS_EN
         if (commit && good_q != 16'hFFFF)
            good_q <= good_q + 16'd1;
         if (reject && bad_q != 16'hFFFF)
            bad_q <= bad_q + 16'd1;
`endif
         unique case (state_q)
            HUNT: begin
               if (byte_ok && bus.rx_byte == SYNC_BYTE) begin
                  state_q <= PAYLOAD;
                  idx_q   <= '0;
                  sum_q   <= '0;
               end
            end
            PAYLOAD: begin
               if (bus.rx_err || gap_hit) begin
                  state_q <= HUNT;
               end else if (bus.rx_valid) begin
                  shadow_q[idx_q[IW-2:0]] <= bus.rx_byte;
                  sum_q <= sum_q + bus.rx_byte;
                  idx_q <= idx_q + IW'(1);
                  if (idx_q == IW'(NUM_BYTES - 1))
                     state_q <= CHECK;
               end
            end
            CHECK: begin
               if (bus.rx_err || bus.rx_valid || gap_hit)
                  state_q <= HUNT;
            end
            default: state_q <= HUNT;
         endcase
      end
   end

   assign bus.data_out         = data_q;
   assign bus.frame_strobe     = strobe_q;
   assign bus.frame_err_strobe = err_q;
   assign bus.stale            = stale_q;
endmodule

// File: doc/frame_receiver.md
Name: frame_receiver

Overview:
- Assembles the scoreboard display frame from the UART receive byte stream.
- Validates each frame and holds the last good frame as the 20-byte data array consumed by the segment decoder.
- Blanks the array to all-zero when frames stop arriving; the decoder treats all-zero as "display off".

Parameters:
NUM_BYTES, 20, payload bytes per frame; equals the decoder's NUM_DATA_BITS.
SYNC_BYTE, 8'hA5, frame start marker.
GAP_CYCLES, 50000, maximum clk cycles between bytes inside a frame before the frame is aborted.
STALE_CYCLES, 50000000, clk cycles without a good frame before output is blanked.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_byte  input  8  received byte from UART
rx_valid  input  1  one-cycle strobe; rx_byte is valid
rx_err  input  1  one-cycle strobe; UART framing or parity error on the current byte
data_out  output  [NUM_BYTES-1:0][7:0]  last good payload; byte 0 is the first payload byte after sync
frame_strobe  output  1  one-cycle pulse when data_out updates
frame_err_strobe  output  1  one-cycle pulse on any aborted or rejected frame
stale  output  1  high while data_out is blanked because no good frame has arrived recently

Behaviour:
- Reset values:
  - data_out all zero.
  - frame_strobe=0, frame_err_strobe=0.
  - stale=1.
  - FSM in HUNT; all counters zero.
- Counter widths are $clog2 of the corresponding parameter + 1. No wrap is permitted; the stale counter saturates.
- FSM states: HUNT, PAYLOAD, CHECK.
  - HUNT:
    - rx_valid && rx_byte==SYNC_BYTE && !rx_err -> PAYLOAD; byte index=0, running sum=0.
    - Any other byte is ignored, with no error strobe.
  - PAYLOAD:
    - Each rx_valid byte is written to shadow[index]; sum += byte (mod 256); index++.
    - When index reaches NUM_BYTES-1 and that byte is accepted -> CHECK.
    - A byte equal to SYNC_BYTE is ordinary payload; it does not resynchronise the frame.
  - CHECK:
    - On the next rx_valid, if (sum + rx_byte) mod 256 == 0: on the following clk edge, data_out <= shadow and frame_strobe=1. Latency is 1 clk from the checksum byte to the update.
    - Otherwise data_out is unchanged and frame_err_strobe=1.
    - The FSM returns to HUNT in both cases.
- Shadow buffer:
  - data_out is never partially updated; it changes only on a commit or on a stale blank.
- Aborts:
  - rx_err in PAYLOAD or CHECK: -> HUNT, frame_err_strobe=1.
  - rx_err in HUNT is ignored.
  - Gap counter: cleared on each accepted byte; counts in PAYLOAD and CHECK. Reaching GAP_CYCLES -> HUNT, frame_err_strobe=1.
- Stale timer:
  - Cleared on commit, and stale<=0 in the same cycle as frame_strobe.
  - Otherwise increments, saturating. On reaching STALE_CYCLES: data_out <= 0, stale<=1.
  - A commit in the same cycle as stale expiry wins: new data, stale=0.
- Simultaneous rx_valid and rx_err: treated as rx_err; the byte is discarded.
- Reset mid-frame: immediate return to reset values. Any partial frame is lost.

Optional Feature:
Macro FRAME_STATS_EN.
- Defined:
  - Adds output ports good_count[15:0] and bad_count[15:0], both reset to 0.
  - good_count increments on each frame_strobe; bad_count increments on each frame_err_strobe.
  - Both saturate at 16'hFFFF.
- Undefined:
  - Ports and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Good frame: send A5, payload all 00 except byte 6=05, checksum FB -> one clk later data_out[6]=05, all other bytes 00, frame_strobe pulses once, stale 1->0.
- Bad checksum: same frame with checksum FA -> frame_err_strobe pulses once, data_out keeps its previous value, FSM back in HUNT; a following good frame is accepted.
- Sync in payload and garbage before sync: send 00 12 A5, then payload with byte 3=A5 and correct checksum -> commit occurs, data_out[3]=A5.
- Gap abort with GAP_CYCLES=16: send A5 and 5 payload bytes, wait 16 cycles -> frame_err_strobe; the remaining bytes are ignored until the next A5; data_out unchanged.
- Stale with STALE_CYCLES=100: commit a good frame, then idle 100 cycles -> data_out all 00, stale=1. Send a good frame whose checksum byte lands on cycle 100 -> new data, stale=0.
- rx_err mid-frame plus reset mid-frame: rx_err on byte 10 -> frame_err_strobe, and with FRAME_STATS_EN bad_count=1. Assert rst_n low mid-frame -> all outputs at reset values immediately.
